// File: rtl/pc_score_accum.sv
// ---------------------------------------------------------------------------
// pc_score_accum
//
// Streaming PCA score generator. Each input beat carries one projected
// component value y_i and that component's inverse eigenvalue. The block
// accumulates y_i^2 * inv_lambda_i into two saturating sums:
//   components 0 .. MAJ_PC_NUM-1       -> major score
//   components MAJ_PC_NUM .. PC_NUM-1  -> minor score
// After PC_NUM beats both scores are offered on a valid/ready output and held
// until accepted. Both accumulators then clear for the next frame.
//
// Build option:
//   PC_SCORE_PIPE_EN  when defined, a register stage sits between the multiply
//                     and the accumulate. A DRAIN state adds the final term,
//                     so out_valid rises 2 cycles after the last beat instead
//                     of 1. Numeric results are identical in both builds.
//
// Parameters:
//   PC_NUM      components per frame (>= 2)
//   MAJ_PC_NUM  leading components counted as major (1 .. PC_NUM-1)
//   DATA_W      width of in_y / in_inv_lambda
//   FRAC_W      fractional bits of both inputs
//
// Ports:
//   clk            clock, rising edge
//   reset          synchronous, active-high
//   in_valid       input beat valid
//   in_ready       block accepts a beat (ACCUM only, low during reset)
//   in_y           signed projected component value, Q(DATA_W-FRAC_W).FRAC_W
//   in_inv_lambda  unsigned 1/eigenvalue, same format
//   out_valid      scores valid
//   out_ready      downstream accepts the scores
//   maj_pc_score   unsigned major score, Q(2*(DATA_W-FRAC_W)).(2*FRAC_W)
//   min_pc_score   unsigned minor score, same format
// ---------------------------------------------------------------------------
module pc_score_accum #(
    parameter int unsigned PC_NUM     = 5,
    parameter int unsigned MAJ_PC_NUM = 2,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FRAC_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_y,
    input  logic [DATA_W-1:0]     in_inv_lambda,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATA_W-1:0]   maj_pc_score,
    output logic [2*DATA_W-1:0]   min_pc_score
);

    localparam int unsigned IdxW  = (PC_NUM > 1) ? $clog2(PC_NUM) : 1;
    localparam int unsigned AccW  = 2 * DATA_W;
    localparam int unsigned ProdW = 3 * DATA_W;

    localparam logic [IdxW-1:0] LastIdx = IdxW'(PC_NUM - 1);
    localparam logic [IdxW-1:0] MajIdx  = IdxW'(MAJ_PC_NUM);

    // -----------------------------------------------------------------------
    // FSM encoding
    // -----------------------------------------------------------------------
`ifdef PC_SCORE_PIPE_EN
    typedef enum logic [1:0] {
        StAccum = 2'd0,
        StDrain = 2'd1,
        StOut   = 2'd2
    } state_e;
`else
    typedef enum logic [0:0] {
        StAccum = 1'b0,
        StOut   = 1'b1
    } state_e;
`endif

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [AccW-1:0] maj_q, maj_d;
    logic [AccW-1:0] min_q, min_d;

    // -----------------------------------------------------------------------
    // Term arithmetic
    // -----------------------------------------------------------------------
    // Squaring at 2*DATA_W keeps the most negative input exact:
    // (-2^(DATA_W-1))^2 = 2^(2*DATA_W-2) still fits unsigned.
    logic signed [AccW-1:0] y_ext;
    logic signed [AccW-1:0] sq_signed;
    logic [AccW-1:0]        sq;
    logic [ProdW-1:0]       prod;
    logic [ProdW-1:0]       term_full;
    logic [AccW-1:0]        term;

    always_comb begin
        y_ext     = {{DATA_W{in_y[DATA_W-1]}}, in_y};
        sq_signed = y_ext * y_ext;
        sq        = sq_signed;
        prod      = {{DATA_W{1'b0}}, sq} * {{AccW{1'b0}}, in_inv_lambda};
        // Floor shift back to 2*FRAC_W fractional bits.
        term_full = prod >> FRAC_W;
        term      = (|term_full[ProdW-1:AccW]) ? {AccW{1'b1}} : term_full[AccW-1:0];
    end

    function automatic logic [AccW-1:0] sat_add(input logic [AccW-1:0] a,
                                                input logic [AccW-1:0] b);
        logic [AccW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[AccW] ? {AccW{1'b1}} : sum[AccW-1:0];
    endfunction

    // -----------------------------------------------------------------------
    // Beat decode
    // -----------------------------------------------------------------------
    logic beat;
    logic beat_is_maj;

    assign beat        = in_valid && (state_q == StAccum);
    assign beat_is_maj = (idx_q < MajIdx);

    // Accumulate source: the live term, or the registered one with the pipe.
    logic            add_en;
    logic            add_maj;
    logic [AccW-1:0] add_term;

`ifdef PC_SCORE_PIPE_EN
    logic [AccW-1:0] term_q, term_d;
    logic            term_maj_q, term_maj_d;
    logic            term_vld_q, term_vld_d;

    always_comb begin
        term_d     = term_q;
        term_maj_d = term_maj_q;
        term_vld_d = beat;
        if (beat) begin
            term_d     = term;
            term_maj_d = beat_is_maj;
        end
        add_en   = term_vld_q;
        add_maj  = term_maj_q;
        add_term = term_q;
    end
`else
    always_comb begin
        add_en   = beat;
        add_maj  = beat_is_maj;
        add_term = term;
    end
`endif

    // -----------------------------------------------------------------------
    // Next-state, accumulators and handshake outputs
    // -----------------------------------------------------------------------
    logic acc_ready;
    logic acc_valid;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        maj_d     = maj_q;
        min_d     = min_q;
        acc_ready = 1'b0;
        acc_valid = 1'b0;

        // No term is ever pending in OUT, so this never races the clear below.
        if (add_en) begin
            if (add_maj) begin
                maj_d = sat_add(maj_q, add_term);
            end else begin
                min_d = sat_add(min_q, add_term);
            end
        end

        unique case (state_q)
            StAccum: begin
                acc_ready = 1'b1;
                if (in_valid) begin
                    if (idx_q == LastIdx) begin
                        idx_d = '0;
`ifdef PC_SCORE_PIPE_EN
                        state_d = StDrain;
`else
                        state_d = StOut;
`endif
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
`ifdef PC_SCORE_PIPE_EN
            StDrain: begin
                // Final registered term lands this cycle.
                state_d = StOut;
            end
`endif
            StOut: begin
                acc_valid = 1'b1;
                if (out_ready) begin
                    maj_d   = '0;
                    min_d   = '0;
                    state_d = StAccum;
                end
            end
            default: begin
                state_d = StAccum;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StAccum;
            idx_q   <= '0;
            maj_q   <= '0;
            min_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            maj_q   <= maj_d;
            min_q   <= min_d;
        end
    end

`ifdef PC_SCORE_PIPE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            term_q     <= '0;
            term_maj_q <= 1'b0;
            term_vld_q <= 1'b0;
        end else begin
            term_q     <= term_d;
            term_maj_q <= term_maj_d;
            term_vld_q <= term_vld_d;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Outputs: forced quiet while reset is asserted.
    // -----------------------------------------------------------------------
    assign in_ready     = acc_ready & ~reset;
    assign out_valid    = acc_valid & ~reset;
    assign maj_pc_score = reset ? '0 : maj_q;
    assign min_pc_score = reset ? '0 : min_q;

`ifndef SYNTHESIS
    // Scores hold while the consumer stalls.
    hold_scores_a : assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready) |=>
            (out_valid && $stable(maj_pc_score) && $stable(min_pc_score)));

    // Never accept input while scores are pending.
    no_overlap_a : assert property (@(posedge clk) disable iff (reset)
        !(in_ready && out_valid));
`endif

endmodule

// File: tb/tb_pc_score_accum.sv
// ---------------------------------------------------------------------------
// tb_pc_score_accum
//
// Self-checking bench for pc_score_accum at default parameters. Directed
// frames come from a table of {inputs, expected scores} records. Random
// frames are scored by an arithmetic reference model. Hand-written sequences
// cover reset in the middle of a frame.
// ---------------------------------------------------------------------------
module tb_pc_score_accum;

    localparam int PC  = 5;
    localparam int MAJ = 2;
`ifdef PC_SCORE_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef longint unsigned u64_t;

    typedef struct {
        logic [PC-1:0][15:0] y;
        logic [PC-1:0][15:0] inv;
        logic [31:0]         maj;
        logic [31:0]         min;
        int                  gap;   // max idle cycles before each beat
        int                  hold;  // cycles out_ready stays low after out_valid
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_y;
    logic [15:0] in_inv_lambda;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] maj_pc_score;
    logic [31:0] min_pc_score;

    int n_checks = 0;
    int n_errors = 0;

    pc_score_accum dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_y          (in_y),
        .in_inv_lambda (in_inv_lambda),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .maj_pc_score  (maj_pc_score),
        .min_pc_score  (min_pc_score)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: real-number rules in integer form, saturating at 2^32-1.
    function automatic void model(input vec_t v, output logic [31:0] maj,
                                  output logic [31:0] min);
        u64_t acc_maj;
        u64_t acc_min;
        acc_maj = 0;
        acc_min = 0;
        for (int i = 0; i < PC; i++) begin
            longint ys;
            u64_t   sq;
            u64_t   inv;
            u64_t   term;
            ys   = $signed(v.y[i]);
            sq   = u64_t'(ys * ys);
            inv  = {48'd0, v.inv[i]};
            term = (sq * inv) >> 8;
            if (term > 64'hFFFF_FFFF) term = 64'hFFFF_FFFF;
            if (i < MAJ) acc_maj = acc_maj + term;
            else         acc_min = acc_min + term;
            if (acc_maj > 64'hFFFF_FFFF) acc_maj = 64'hFFFF_FFFF;
            if (acc_min > 64'hFFFF_FFFF) acc_min = 64'hFFFF_FFFF;
        end
        maj = acc_maj[31:0];
        min = acc_min[31:0];
    endfunction

    // Stream one frame, check out_valid latency, hold, and post-accept state.
    task automatic run_frame(input vec_t v, input string name);
        int lat;
        int waits;
        out_ready = (v.hold == 0);
        for (int b = 0; b < PC; b++) begin
            int gap_c;
            gap_c    = (v.gap > 0) ? int'($urandom_range(v.gap, 0)) : 0;
            in_valid = 1'b0;
            repeat (gap_c) begin
                check({name, "_bubble_valid"}, out_valid, 0);
                @(posedge clk); #1;
            end
            in_valid      = 1'b1;
            in_y          = v.y[b];
            in_inv_lambda = v.inv[b];
            waits = 0;
            while (!in_ready && waits < 50) begin
                @(posedge clk); #1;
                waits++;
            end
            if (!in_ready) check({name, "_in_ready_timeout"}, in_ready, 1);
            check({name, "_early_valid"}, out_valid, 0);
            @(posedge clk); #1;
        end
        in_valid      = 1'b0;
        in_y          = '0;
        in_inv_lambda = '0;

        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, lat, LAT);
        check({name, "_maj"}, maj_pc_score, v.maj);
        check({name, "_min"}, min_pc_score, v.min);

        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk); #1;
            check({name, "_hold_valid"}, out_valid, 1);
            check({name, "_hold_in_ready"}, in_ready, 0);
            check({name, "_hold_maj"}, maj_pc_score, v.maj);
            check({name, "_hold_min"}, min_pc_score, v.min);
        end

        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_post_valid"}, out_valid, 0);
        check({name, "_post_maj"}, maj_pc_score, 0);
        check({name, "_post_min"}, min_pc_score, 0);
        check({name, "_post_in_ready"}, in_ready, 1);
    endtask

    vec_t dir[9];
    vec_t basic;

    initial begin
        // Basic frame: y = [2.0, 1.0, 3.0, 0.5, 1.0], inv = [0.5, 1.0, 0.25, 2.0, 1.0].
        basic.y    = {16'h0100, 16'h0080, 16'h0300, 16'h0100, 16'h0200};
        basic.inv  = {16'h0100, 16'h0200, 16'h0040, 16'h0100, 16'h0080};
        basic.maj  = 32'h0003_0000;
        basic.min  = 32'h0003_C000;
        basic.gap  = 0;
        basic.hold = 0;

        dir[0] = basic;
        // Negated inputs give identical scores.
        dir[1]   = basic;
        dir[1].y = {16'hFF00, 16'hFF80, 16'hFD00, 16'hFF00, 16'hFE00};
        // Most negative input is squared exactly.
        dir[2]     = basic;
        dir[2].y   = {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8000};
        dir[2].inv = {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100};
        dir[2].maj = 32'h4000_0000;
        dir[2].min = 32'h0000_0000;
        // Major term saturates; minor untouched.
        dir[3]        = basic;
        dir[3].y[0]   = 16'h7FFF;
        dir[3].inv[0] = 16'hFFFF;
        dir[3].maj    = 32'hFFFF_FFFF;
        // Backpressure for 10 cycles, then a clean frame.
        dir[4]      = basic;
        dir[4].hold = 10;
        dir[5]      = basic;
        // Bubbles between beats.
        dir[6]     = basic;
        dir[6].gap = 3;
        // Both sums saturate, then next frame must start from zero.
        dir[7].y    = {PC{16'h7FFF}};
        dir[7].inv  = {PC{16'hFFFF}};
        dir[7].maj  = 32'hFFFF_FFFF;
        dir[7].min  = 32'hFFFF_FFFF;
        dir[7].gap  = 1;
        dir[7].hold = 2;
        dir[8]      = basic;

        reset         = 1'b1;
        in_valid      = 1'b0;
        in_y          = '0;
        in_inv_lambda = '0;
        out_ready     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_maj", maj_pc_score, 0);
        check("reset_min", min_pc_score, 0);
        reset = 1'b0;
        #1;
        check("after_reset_in_ready", in_ready, 1);
        check("after_reset_out_valid", out_valid, 0);

        for (int i = 0; i < 9; i++) begin
            run_frame(dir[i], $sformatf("dir%0d", i));
        end

        // Reset in the middle of a frame: 3 beats, 1-cycle reset pulse.
        out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            in_valid      = 1'b1;
            in_y          = basic.y[b];
            in_inv_lambda = basic.inv[b];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check("midrst_pre_in_ready", in_ready, 0);
        check("midrst_pre_out_valid", out_valid, 0);
        check("midrst_pre_maj", maj_pc_score, 0);
        check("midrst_pre_min", min_pc_score, 0);
        @(posedge clk); #1;
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_maj", maj_pc_score, 0);
        check("midrst_min", min_pc_score, 0);
        reset = 1'b0;
        #1;
        check("midrst_release_in_ready", in_ready, 1);
        run_frame(basic, "midrst_frame");

        // Random frames against the reference model.
        for (int r = 0; r < 30; r++) begin
            vec_t v;
            int   mode;
            mode = int'($urandom_range(2, 0));
            for (int i = 0; i < PC; i++) begin
                if (mode == 0) begin
                    v.y[i]   = 16'($urandom_range(32'h0800, 0) - 32'h0400);
                    v.inv[i] = 16'($urandom_range(32'h0400, 0));
                end else if (mode == 1) begin
                    v.y[i]   = 16'($urandom);
                    v.inv[i] = 16'($urandom_range(32'h0100, 0));
                end else begin
                    v.y[i]   = 16'($urandom);
                    v.inv[i] = 16'($urandom);
                end
            end
            v.gap  = int'($urandom_range(3, 0));
            v.hold = int'($urandom_range(3, 0));
            model(v, v.maj, v.min);
            run_frame(v, $sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
